jtkicker_gfx_slots: RTL and testbench

Responder for the graphics ROM fetch interfaces driven by the video subsystem. It serves the scroll tile fetch port (free-running address, no chip select) and the object fetch port (address plus chip select) from a shared SDRAM read channel, returning 32-bit words with an `ok` qualifier. It sits between the video top level and the SDRAM controller. It holds a one-word cache per slot and arbitrates the two slots onto one SDRAM request/acknowledge/ready handshake.

---
 rtl/jtkicker_gfx_pkg.sv | 30 +++
 rtl/jtkicker_gfx_cache1.sv | 48 ++++
 rtl/jtkicker_gfx_slots.sv | 146 ++++++++++++++
 tb/tb_jtkicker_gfx_slots.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkicker_gfx_pkg.sv
// jtkicker_gfx_pkg
// Shared definitions for the graphics ROM slot responder.
//   SDRAM_AW  : word address width of the SDRAM read channel
//   SLOT_SCR  : slot id of the scroll tile fetch port
//   SLOT_OBJ  : slot id of the object fetch port
//   gfx_state_e : request FSM states (IDLE, REQ, WAIT)
//   rom_addr()  : region base plus zero-extended slot address, modulo 2^22
package jtkicker_gfx_pkg;

  localparam int SDRAM_AW = 22;

  localparam logic SLOT_SCR = 1'b0;
  localparam logic SLOT_OBJ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } gfx_state_e;

  // Carry out of bit 21 is simply dropped, so regions placed near the top
  // of the SDRAM wrap around to address zero.
  function automatic logic [SDRAM_AW-1:0] rom_addr(
    input logic [SDRAM_AW-1:0] base,
    input logic [13:0]         addr
  );
    return base + {{(SDRAM_AW-14){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/jtkicker_gfx_cache1.sv
// jtkicker_gfx_cache1
// Single-entry cache: one address/data/valid register with a combinational
// hit compare against the address currently presented by the video side.
//   clk, rst_n : clock and asynchronous active-low reset
//   addr       : address currently requested by the fetch port
//   cs         : request enable (tie high for ports without a chip select)
//   we         : write strobe from the fill logic
//   wr_addr    : address the incoming word belongs to
//   wr_data    : incoming word
//   data       : stored word, driven whether or not it is a hit
//   hit        : stored word is valid for addr while cs is high
module jtkicker_gfx_cache1 #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   data,
  output logic          hit
);

  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          valid_q;

  // The entry is only ever overwritten by a completed fill; it is never
  // invalidated by an address change, so returning to an old address hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (we) begin
      addr_q  <= wr_addr;
      data_q  <= wr_data;
      valid_q <= 1'b1;
    end
  end

  // Zero-latency hit path: ok drops in the same cycle the address moves.
  assign hit  = valid_q & cs & (addr_q == addr);
  assign data = data_q;

endmodule

// File: rtl/jtkicker_gfx_slots.sv
// jtkicker_gfx_slots
// Serves the scroll tile and object graphics fetch ports from one shared
// SDRAM read channel. Each port has a one-word cache; misses are arbitrated
// onto a single req/ack/rdy handshake.
//   clk, rst_n             : 48 MHz clock, asynchronous active-low reset
//   scr_addr/data/ok       : scroll port, always requesting
//   obj_cs/addr/data/ok    : object port, requesting while obj_cs is high
//   sdram_req/addr         : registered read request, held until ack
//   sdram_ack              : controller accepted the request
//   sdram_rdy/din          : one-cycle read data strobe and data
module jtkicker_gfx_slots
  import jtkicker_gfx_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET = 22'h0,
  parameter logic [21:0] OBJ_OFFSET = 22'h2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [12:0]         scr_addr,
  output logic [31:0]         scr_data,
  output logic                scr_ok,
  input  logic                obj_cs,
  input  logic [13:0]         obj_addr,
  output logic [31:0]         obj_data,
  output logic                obj_ok,
  output logic                sdram_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [31:0]         sdram_din
);

  gfx_state_e          state_q, state_nx;
  logic                sel_q;
  logic                last_q;
  logic [13:0]         lat_q;

  logic                scr_hit, obj_hit;
  logic                scr_pend, obj_pend;
  logic                pick_obj;
  logic                start;
  logic                fill;
  logic                scr_we, obj_we;
  logic [13:0]         lat_nx;
  logic [SDRAM_AW-1:0] addr_nx;

  jtkicker_gfx_cache1 #(.AW(13)) u_scr (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (scr_addr),
    .cs      (1'b1),
    .we      (scr_we),
    .wr_addr (lat_q[12:0]),
    .wr_data (sdram_din),
    .data    (scr_data),
    .hit     (scr_hit)
  );

  jtkicker_gfx_cache1 #(.AW(14)) u_obj (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (obj_addr),
    .cs      (obj_cs),
    .we      (obj_we),
    .wr_addr (lat_q),
    .wr_data (sdram_din),
    .data    (obj_data),
    .hit     (obj_hit)
  );

  assign scr_ok   = scr_hit;
  assign obj_ok   = obj_hit;

  assign scr_pend = ~scr_hit;
  assign obj_pend = obj_cs & ~obj_hit;

  // With both slots missing, the one not served last goes first, so neither
  // port can starve the other.
  assign pick_obj = obj_pend & (~scr_pend | (last_q == SLOT_SCR));

  // Data may arrive together with the ack; it is captured in that same
  // cycle rather than waiting for WAIT. rdy outside a transaction is ignored.
  assign fill = sdram_rdy & ((state_q == WAIT) | ((state_q == REQ) & sdram_ack));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (scr_pend | obj_pend) state_nx = REQ;
      REQ:  if (sdram_ack) state_nx = sdram_rdy ? IDLE : WAIT;
      WAIT: if (sdram_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: request launch values and slot write strobes
  always_comb begin
    start   = 1'b0;
    lat_nx  = {1'b0, scr_addr};
    addr_nx = rom_addr(SCR_OFFSET, {1'b0, scr_addr});
    scr_we  = 1'b0;
    obj_we  = 1'b0;
    if ((state_q == IDLE) && (scr_pend || obj_pend)) begin
      start = 1'b1;
      if (pick_obj) begin
        lat_nx  = obj_addr;
        addr_nx = rom_addr(OBJ_OFFSET, obj_addr);
      end
    end
    if (fill) begin
      scr_we = (sel_q == SLOT_SCR);
      obj_we = (sel_q == SLOT_OBJ);
    end
  end

  // Registered request side. The slot address is latched at launch so a
  // fill stores the address that was actually fetched, even if the port
  // has moved on; such a stale fill simply does not hit and is re-fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sel_q      <= SLOT_SCR;
      last_q     <= SLOT_OBJ;
      lat_q      <= '0;
    end else begin
      sdram_req <= (state_nx == REQ);
      if (start) begin
        sdram_addr <= addr_nx;
        sel_q      <= pick_obj ? SLOT_OBJ : SLOT_SCR;
        last_q     <= pick_obj ? SLOT_OBJ : SLOT_SCR;
        lat_q      <= lat_nx;
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_gfx_slots.sv
// tb_jtkicker_gfx_slots
// Self-checking bench: directed scenarios plus randomized port traffic,
// compared every cycle against a transaction-level model of the two slots.
module tb_jtkicker_gfx_slots;

  localparam logic [21:0] OBJ_OFF = 22'h2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] scr_addr = '0;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic        obj_cs = 1'b0;
  logic [13:0] obj_addr = '0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        sdram_rdy = 1'b0;
  logic [31:0] sdram_din = '0;

  // second instance with a wrapping object region
  logic        w_rst_n = 1'b0;
  logic [12:0] w_scr_addr = '0;
  logic [31:0] w_scr_data;
  logic        w_scr_ok;
  logic        w_obj_cs = 1'b0;
  logic [13:0] w_obj_addr = '0;
  logic [31:0] w_obj_data;
  logic        w_obj_ok;
  logic        w_req;
  logic [21:0] w_sdram_addr;
  logic        w_ack = 1'b0;
  logic        w_rdy = 1'b0;
  logic [31:0] w_din = '0;

  always #5 clk = ~clk;

  jtkicker_gfx_slots dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  jtkicker_gfx_slots #(.SCR_OFFSET(22'h0), .OBJ_OFFSET(22'h3FFFF0)) dut_w (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .scr_addr   (w_scr_addr),
    .scr_data   (w_scr_data),
    .scr_ok     (w_scr_ok),
    .obj_cs     (w_obj_cs),
    .obj_addr   (w_obj_addr),
    .obj_data   (w_obj_data),
    .obj_ok     (w_obj_ok),
    .sdram_req  (w_req),
    .sdram_addr (w_sdram_addr),
    .sdram_ack  (w_ack),
    .sdram_rdy  (w_rdy),
    .sdram_din  (w_din)
  );

  int checks = 0;
  int errors = 0;

  // transaction-level model of the two slots
  logic        ms_valid, mo_valid;
  logic [12:0] ms_addr;
  logic [13:0] mo_addr;
  logic [31:0] ms_data, mo_data;
  bit          last_obj;
  bit          busy, acked;
  bit          m_sel_obj;
  logic [13:0] m_lat;
  logic [21:0] m_req_addr;
  bit          m_filled, m_fill_obj;
  int          fill_count = 0;

  // controller
  bit          rand_ctrl = 0;
  bit          combo = 0;
  int          ack_dly = 2, rdy_dly = 4, cnt = 0;
  logic [31:0] fill_word = 32'hDEADBEEF;
  int          prev_stage = 0;

  logic [21:0] dut_log[$];
  bit          prev_req = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  function automatic bit scrHit();
    return ms_valid && (ms_addr == scr_addr);
  endfunction

  function automatic bit objHit();
    return mo_valid && (mo_addr == obj_addr) && obj_cs;
  endfunction

  function automatic int stage();
    return !busy ? 0 : (acked ? 2 : 1);
  endfunction

  task automatic modelReset();
    ms_valid = 0; mo_valid = 0;
    ms_addr = '0; mo_addr = '0;
    ms_data = '0; mo_data = '0;
    last_obj = 1; busy = 0; acked = 0;
    cnt = 0; prev_stage = 0;
  endtask

  task automatic modelFill();
    if (m_sel_obj) begin
      mo_valid = 1; mo_addr = m_lat; mo_data = sdram_din;
    end else begin
      ms_valid = 1; ms_addr = m_lat[12:0]; ms_data = sdram_din;
    end
    m_filled = 1; m_fill_obj = m_sel_obj; fill_count++;
    busy = 0; acked = 0;
  endtask

  // What the clock edge just taken must have done, given the inputs held at it.
  task automatic modelStep();
    bit sp, op;
    m_filled = 0;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (!busy) begin
      sp = !scrHit();
      op = obj_cs && !objHit();
      if (sp || op) begin
        m_sel_obj = op && (!sp || !last_obj);
        last_obj = m_sel_obj;
        if (m_sel_obj) begin
          m_lat = obj_addr;
          m_req_addr = OBJ_OFF + {8'd0, obj_addr};
        end else begin
          m_lat = {1'b0, scr_addr};
          m_req_addr = {9'd0, scr_addr};
        end
        busy = 1; acked = 0;
      end
    end else if (!acked) begin
      if (sdram_ack) begin
        if (sdram_rdy) modelFill();
        else acked = 1;
      end
    end else if (sdram_rdy) begin
      modelFill();
    end
  endtask

  task automatic compareAll();
    checkOutput("sdram_req", {31'd0, sdram_req}, {31'd0, stage() == 1});
    if (stage() == 1) checkOutput("sdram_addr", {10'd0, sdram_addr}, {10'd0, m_req_addr});
    checkOutput("scr_ok", {31'd0, scr_ok}, {31'd0, scrHit()});
    checkOutput("scr_data", scr_data, ms_data);
    checkOutput("obj_ok", {31'd0, obj_ok}, {31'd0, objHit()});
    checkOutput("obj_data", obj_data, mo_data);
    if (sdram_req && !prev_req) dut_log.push_back(sdram_addr);
    prev_req = sdram_req;
  endtask

  task automatic driveController();
    int st;
    st = stage();
    sdram_ack = 0;
    sdram_rdy = 0;
    if (rand_ctrl) sdram_din = $urandom;
    if (st != prev_stage) begin
      cnt = 0;
      if (rand_ctrl && st == 1) begin
        ack_dly = $urandom_range(0, 3);
        rdy_dly = $urandom_range(0, 4);
        combo = ($urandom_range(0, 4) == 0);
        fill_word = $urandom;
      end
    end
    prev_stage = st;
    if (st == 1) begin
      if (cnt == ack_dly) begin
        sdram_ack = 1;
        if (combo) begin sdram_rdy = 1; sdram_din = fill_word; end
      end
      cnt++;
    end else if (st == 2) begin
      if (cnt == rdy_dly) begin sdram_rdy = 1; sdram_din = fill_word; end
      cnt++;
    end
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 9) == 0) scr_addr = 13'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) obj_cs = ~obj_cs;
    if ($urandom_range(0, 9) == 0)
      obj_addr = 14'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 14'h3FF8 : 14'h0);
  endtask

  task automatic runCycle(input bit stim);
    @(negedge clk);
    modelStep();
    compareAll();
    driveController();
    if (stim) applyStimulus();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 0; sdram_ack = 0; sdram_rdy = 0;
    runCycle(0);
    runCycle(0);
    rst_n = 1;
    dut_log.delete();
  endtask

  task automatic waitStage(input int target, input int budget, input string name);
    int c;
    for (c = 0; c < budget && stage() != target; c++) runCycle(0);
    if (stage() != target) timeoutFail(name);
  endtask

  task automatic waitFills(input int n, input int budget, input string name);
    int target;
    target = fill_count + n;
    for (int c = 0; c < budget && fill_count < target; c++) runCycle(0);
    if (fill_count < target) timeoutFail(name);
  endtask

  initial begin
    logic [21:0] w_log[$];
    bit          w_prev;
    int          target;

    modelReset();

    // reset values
    #1;
    checkOutput("rst_sdram_req", {31'd0, sdram_req}, 32'd0);
    checkOutput("rst_sdram_addr", {10'd0, sdram_addr}, 32'd0);
    checkOutput("rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    checkOutput("rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    checkOutput("rst_scr_data", scr_data, 32'd0);

    // single scroll fetch
    $display("[TB] scroll fetch");
    scr_addr = 13'h0010; obj_cs = 0;
    ack_dly = 2; rdy_dly = 4; combo = 0; fill_word = 32'hDEADBEEF;
    resetDut();
    waitFills(1, 40, "t1_fill");
    runCycle(0);
    checkOutput("t1_scr_ok", {31'd0, scr_ok}, 32'd1);
    checkOutput("t1_scr_data", scr_data, 32'hDEADBEEF);
    checkOutput("t1_obj_ok", {31'd0, obj_ok}, 32'd0);
    repeat (5) runCycle(0);
    checkOutput("t1_req_count", dut_log.size(), 32'd1);
    if (dut_log.size() > 0) checkOutput("t1_req_addr", {10'd0, dut_log[0]}, 32'h0010);

    // alternation with both slots pending
    $display("[TB] alternation");
    scr_addr = 13'd1; obj_cs = 1; obj_addr = 14'd5;
    ack_dly = 1; rdy_dly = 1;
    resetDut();
    target = fill_count + 4;
    for (int c = 0; c < 200 && fill_count < target; c++) begin
      runCycle(0);
      fill_word = fill_word + 32'h1111;
      if (m_filled) begin
        if (m_fill_obj) obj_addr = obj_addr + 14'd1;
        else scr_addr = scr_addr + 13'd1;
      end
    end
    if (fill_count < target) timeoutFail("t2_fills");
    if (dut_log.size() >= 4) begin
      checkOutput("t2_req0", {10'd0, dut_log[0]}, 32'h0001);
      checkOutput("t2_req1", {10'd0, dut_log[1]}, 32'h2005);
      checkOutput("t2_req2", {10'd0, dut_log[2]}, 32'h0002);
      checkOutput("t2_req3", {10'd0, dut_log[3]}, 32'h2006);
      for (int i = 1; i < 4; i++)
        checkOutput("t2_alternate", {31'd0, dut_log[i] >= 22'h2000}, {31'd0, dut_log[i-1] < 22'h2000});
    end else begin
      timeoutFail("t2_req_count");
    end

    // stale fill
    $display("[TB] stale fill");
    obj_cs = 0; scr_addr = 13'd3;
    ack_dly = 1; rdy_dly = 3; fill_word = 32'h33333333;
    resetDut();
    waitStage(2, 30, "t3_wait");
    scr_addr = 13'd4;
    #1 checkOutput("t3_ok_drop", {31'd0, scr_ok}, 32'd0);
    waitFills(1, 30, "t3_fill");
    #1 checkOutput("t3_stale_ok", {31'd0, scr_ok}, 32'd0);
    scr_addr = 13'd3;
    #1 checkOutput("t3_stored_addr", {31'd0, scr_ok}, 32'd1);
    scr_addr = 13'd4;
    #1;
    fill_word = 32'h44444444;
    waitFills(1, 30, "t3_refill");
    runCycle(0);
    checkOutput("t3_req_count", dut_log.size(), 32'd2);
    if (dut_log.size() >= 2) checkOutput("t3_req1", {10'd0, dut_log[1]}, 32'h0004);
    checkOutput("t3_final_ok", {31'd0, scr_ok}, 32'd1);

    // obj_cs dropped during the request
    $display("[TB] obj_cs drop");
    scr_addr = 13'd0; obj_cs = 0;
    ack_dly = 2; rdy_dly = 2; fill_word = 32'h11110000;
    resetDut();
    waitFills(1, 30, "t4_scr_fill");
    obj_cs = 1; obj_addr = 14'd9; fill_word = 32'hCAFE0009;
    waitStage(1, 30, "t4_req");
    obj_cs = 0;
    waitFills(1, 30, "t4_obj_fill");
    repeat (3) runCycle(0);
    checkOutput("t4_ok_cs_low", {31'd0, obj_ok}, 32'd0);
    checkOutput("t4_req_count", dut_log.size(), 32'd2);
    if (dut_log.size() >= 2) checkOutput("t4_req1", {10'd0, dut_log[1]}, 32'h2009);
    obj_cs = 1;
    #1;
    checkOutput("t4_ok_cs_back", {31'd0, obj_ok}, 32'd1);
    checkOutput("t4_obj_data", obj_data, 32'hCAFE0009);
    repeat (3) runCycle(0);

    // wrapping object region on the second instance
    $display("[TB] address wrap");
    w_scr_addr = 13'd0; w_obj_cs = 1; w_obj_addr = 14'h0020; w_prev = 0;
    @(negedge clk);
    w_rst_n = 1;
    for (int c = 0; c < 40 && w_log.size() < 2; c++) begin
      runCycle(0);
      w_ack = 0; w_rdy = 0;
      if (w_req) begin
        if (!w_prev) w_log.push_back(w_sdram_addr);
        w_ack = 1; w_rdy = 1; w_din = 32'hA5A50000 + 32'(c);
      end
      w_prev = w_req;
    end
    runCycle(0);
    w_ack = 0; w_rdy = 0;
    if (w_log.size() >= 2) begin
      checkOutput("t5_scr_req", {10'd0, w_log[0]}, 32'h000000);
      checkOutput("t5_wrap_addr", {10'd0, w_log[1]}, 32'h000010);
    end else begin
      timeoutFail("t5_requests");
    end
    #1 checkOutput("t5_obj_ok", {31'd0, w_obj_ok}, 32'd1);

    // reset asserted while waiting for data
    $display("[TB] reset in WAIT");
    scr_addr = 13'd7; obj_cs = 0;
    ack_dly = 0; rdy_dly = 6; fill_word = 32'h77777777;
    resetDut();
    waitStage(2, 30, "t6_wait");
    runCycle(0);
    rst_n = 0;
    #1;
    checkOutput("t6_req", {31'd0, sdram_req}, 32'd0);
    checkOutput("t6_scr_ok", {31'd0, scr_ok}, 32'd0);
    checkOutput("t6_obj_ok", {31'd0, obj_ok}, 32'd0);
    checkOutput("t6_scr_data", scr_data, 32'd0);
    runCycle(0);
    rst_n = 1; sdram_rdy = 1; sdram_din = 32'h12345678;
    runCycle(0);
    checkOutput("t6_late_rdy_ok", {31'd0, scr_ok}, 32'd0);
    checkOutput("t6_late_rdy_data", scr_data, 32'd0);
    waitFills(1, 40, "t6_refill");
    runCycle(0);
    checkOutput("t6_refill_data", scr_data, 32'h77777777);

    // randomized traffic
    $display("[TB] random traffic");
    rand_ctrl = 1;
    resetDut();
    repeat (4000) runCycle(1);
    rand_ctrl = 0;
    target = fill_count;
    checkOutput("rand_progress", {31'd0, target > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
